// File: rtl/osg_pkg.sv
// Shared definitions for the optical signal generator light-pulse path.
// Latency: n/a (constants, types and a pure helper function).
// Backpressure: n/a.
package osg_pkg;

  // Time-base selector codes carried on pl_mlt
  localparam logic [4:0] MLT_1    = 5'd1;
  localparam logic [4:0] MLT_100  = 5'd2;
  localparam logic [4:0] MLT_100K = 5'd3;

  // Prescaler counter width and the clocks-per-tick divider values
  localparam int         PRE_W    = 17;
  localparam logic [PRE_W-1:0] DIV_1    = 17'd1;
  localparam logic [PRE_W-1:0] DIV_100  = 17'd100;
  localparam logic [PRE_W-1:0] DIV_100K = 17'd100000;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_HIGH     = 3'd1,
    ST_LOW      = 3'd2,
    ST_DONE     = 3'd3,
    ST_WAIT_REL = 3'd4
  } pl_state_e;

  // Unknown codes fall back to one clock per tick
  function automatic logic [PRE_W-1:0] mlt_to_div(input logic [4:0] mlt);
    case (mlt)
      MLT_1:    return DIV_1;
      MLT_100:  return DIV_100;
      MLT_100K: return DIV_100K;
      default:  return DIV_1;
    endcase
  endfunction

endpackage

// File: rtl/light_pulse_gen_if.sv
// Launch/config/status bundle between the sequencer side and light_pulse_gen.
// Latency: n/a (wires only).
// Backpressure: none; launch is a level, End_Flg a one-cycle strobe.
interface light_pulse_gen_if #(
  parameter int CNT_W = 17,
  parameter int NUM_W = 8
);
  logic             PL_launch;
  logic [CNT_W-1:0] pl_width;
  logic [CNT_W-1:0] pl_gap;
  logic [NUM_W-1:0] pl_num;
  logic [4:0]       pl_mlt;
  logic             PL_out;
  logic             busy;
  logic             End_Flg;
  logic [NUM_W-1:0] pulse_cnt;

  modport master (
    output PL_launch, pl_width, pl_gap, pl_num, pl_mlt,
    input  PL_out, busy, End_Flg, pulse_cnt
  );

  modport slave (
    input  PL_launch, pl_width, pl_gap, pl_num, pl_mlt,
    output PL_out, busy, End_Flg, pulse_cnt
  );
endinterface

// File: rtl/pl_prescaler.sv
// Clock-enable prescaler: emits tick once every div clocks.
// Latency: tick is combinational from the count; first tick div clocks after clr.
// Backpressure: none; clr restarts the count so a new phase starts tick-aligned.
module pl_prescaler
  import osg_pkg::*;
(
  input  logic             clk_PL,
  input  logic             rst_PL,
  input  logic             clr,
  input  logic [PRE_W-1:0] div,
  output logic             tick
);

  logic [PRE_W-1:0] cnt_q, cnt_d;
  logic             at_top;

  // Count 0..div-1, wrapping on tick and restarting on clr
  always_comb begin
    at_top = (cnt_q == (div - PRE_W'(1)));
    cnt_d  = cnt_q + PRE_W'(1);
    if (clr || at_top) begin
      cnt_d = '0;
    end
  end

  // Count register
  always_ff @(posedge clk_PL or posedge rst_PL) begin
    if (rst_PL) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = at_top;

endmodule

// File: rtl/light_pulse_gen.sv
// Light-pulse train generator armed by a rising edge of PL_launch.
// Latency: PL_out/busy rise the cycle after the launch edge; End_Flg one cycle after last high cycle.
// Backpressure: none; dropping PL_launch mid-train aborts, one train per launch edge.
module light_pulse_gen
  import osg_pkg::*;
#(
  parameter int CNT_W = 17,
  parameter int NUM_W = 8
) (
  input  logic        clk_PL,
  input  logic        rst_PL,
  light_pulse_gen_if.slave pl_if
);

  pl_state_e        state_q, state_d;
  logic             launch_q, launch_d;
  logic [CNT_W-1:0] width_q, width_d;
  logic [CNT_W-1:0] gap_q, gap_d;
  logic [NUM_W-1:0] num_q, num_d;
  logic [PRE_W-1:0] div_q, div_d;
  logic [CNT_W-1:0] tick_cnt_q, tick_cnt_d;
  logic [NUM_W-1:0] pulse_cnt_q, pulse_cnt_d;
  logic [CNT_W-1:0] gap_eff;
  logic             start;
  logic             tick;
  logic             clr;

  pl_prescaler u_prescaler (
    .clk_PL (clk_PL),
    .rst_PL (rst_PL),
    .clr    (clr),
    .div    (div_q),
    .tick   (tick)
  );

  // Edge detect, start-time latching, phase sequencing and counters
  always_comb begin
    start       = pl_if.PL_launch & ~launch_q;
    launch_d    = pl_if.PL_launch;
    state_d     = state_q;
    width_d     = width_q;
    gap_d       = gap_q;
    num_d       = num_q;
    div_d       = div_q;
    pulse_cnt_d = pulse_cnt_q;
    gap_eff     = (gap_q == '0) ? CNT_W'(1) : gap_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          width_d     = pl_if.pl_width;
          gap_d       = pl_if.pl_gap;
          num_d       = pl_if.pl_num;
          div_d       = mlt_to_div(pl_if.pl_mlt);
          pulse_cnt_d = '0;
          if (pl_if.pl_num == '0 || pl_if.pl_width == '0) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_HIGH;
          end
        end
      end
      ST_HIGH: begin
        // Abort takes priority over a coincident phase-end tick
        if (!pl_if.PL_launch) begin
          state_d = ST_IDLE;
        end else if (tick && (tick_cnt_q + CNT_W'(1)) == width_q) begin
          pulse_cnt_d = pulse_cnt_q + NUM_W'(1);
          state_d     = ((pulse_cnt_q + NUM_W'(1)) == num_q) ? ST_DONE : ST_LOW;
        end
      end
      ST_LOW: begin
        if (!pl_if.PL_launch) begin
          state_d = ST_IDLE;
        end else if (tick && (tick_cnt_q + CNT_W'(1)) == gap_eff) begin
          state_d = ST_HIGH;
        end
      end
      ST_DONE: begin
        state_d = ST_WAIT_REL;
      end
      ST_WAIT_REL: begin
        if (!pl_if.PL_launch) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Every state change (including start) re-aligns prescaler and tick counter
    clr        = (state_d != state_q);
    tick_cnt_d = tick_cnt_q;
    if (clr) begin
      tick_cnt_d = '0;
    end else if (tick) begin
      tick_cnt_d = tick_cnt_q + CNT_W'(1);
    end
  end

  // State and datapath registers; launch history resets high so a level
  // already present at reset release is not taken as an edge
  always_ff @(posedge clk_PL or posedge rst_PL) begin
    if (rst_PL) begin
      state_q     <= ST_IDLE;
      launch_q    <= 1'b1;
      width_q     <= '0;
      gap_q       <= '0;
      num_q       <= '0;
      div_q       <= DIV_1;
      tick_cnt_q  <= '0;
      pulse_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      launch_q    <= launch_d;
      width_q     <= width_d;
      gap_q       <= gap_d;
      num_q       <= num_d;
      div_q       <= div_d;
      tick_cnt_q  <= tick_cnt_d;
      pulse_cnt_q <= pulse_cnt_d;
    end
  end

  assign pl_if.PL_out    = (state_q == ST_HIGH);
  assign pl_if.busy      = (state_q == ST_HIGH) || (state_q == ST_LOW);
  assign pl_if.End_Flg   = (state_q == ST_DONE);
  assign pl_if.pulse_cnt = pulse_cnt_q;

endmodule

// File: tb/tb_light_pulse_gen.sv
// Scoreboard bench for light_pulse_gen: expected pulses and end strobes are
// queued by the stimulus and consumed by a negedge monitor.
module tb_light_pulse_gen;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   lc;

  light_pulse_gen_if #(.CNT_W(17), .NUM_W(8)) pl_if ();

  light_pulse_gen #(.CNT_W(17), .NUM_W(8)) dut (
    .clk_PL (clk),
    .rst_PL (rst),
    .pl_if  (pl_if)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {int cyc; int len;} run_t;
  typedef struct {int cyc; int cnt;} end_t;
  run_t run_q[$];
  end_t end_q[$];
  run_t er;
  end_t ee;
  bit   run_active = 1'b0;
  int   run_start  = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic cfg(input int mlt, input int w, input int g, input int n);
    pl_if.pl_mlt   = 5'(mlt);
    pl_if.pl_width = 17'(w);
    pl_if.pl_gap   = 17'(g);
    pl_if.pl_num   = 8'(n);
  endtask

  task automatic launch(output int l);
    pl_if.PL_launch = 1'b1;
    l = cyc;
  endtask

  task automatic exp_run(input int c, input int len);
    run_t r;
    r.cyc = c;
    r.len = len;
    run_q.push_back(r);
  endtask

  task automatic exp_end(input int c, input int cnt);
    end_t e;
    e.cyc = c;
    e.cnt = cnt;
    end_q.push_back(e);
  endtask

  // Monitor: measure each PL_out high run and each End_Flg strobe
  always @(negedge clk) begin
    if (rst) begin
      run_active = 1'b0;
    end else begin
      if (pl_if.PL_out && !run_active) begin
        run_active = 1'b1;
        run_start  = cyc;
      end else if (!pl_if.PL_out && run_active) begin
        run_active = 1'b0;
        if (run_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_pulse: start %0d len %0d, none expected", run_start, cyc - run_start);
        end else begin
          er = run_q.pop_front();
          check("pulse_start", run_start, er.cyc);
          check("pulse_len", cyc - run_start, er.len);
        end
      end
      if (pl_if.End_Flg) begin
        if (end_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_end: End_Flg at %0d, none expected", cyc);
        end else begin
          ee = end_q.pop_front();
          check("end_cycle", cyc, ee.cyc);
          check("end_pulse_cnt", int'(pl_if.pulse_cnt), ee.cnt);
          check("end_pl_out_low", int'(pl_if.PL_out), 0);
          check("end_busy_low", int'(pl_if.busy), 0);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    pl_if.PL_launch = 1'b0;
    cfg(1, 3, 2, 2);
    #3;
    check("rst_pl_out", int'(pl_if.PL_out), 0);
    check("rst_busy", int'(pl_if.busy), 0);
    check("rst_end", int'(pl_if.End_Flg), 0);
    check("rst_pulse_cnt", int'(pl_if.pulse_cnt), 0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    tick(3);

    // Basic train, launch then held high: exactly one train
    launch(lc);
    exp_run(lc + 1, 3);
    exp_run(lc + 6, 3);
    exp_end(lc + 9, 2);
    tick(1);
    check("busy_first_cycle", int'(pl_if.busy), 1);
    tick(30);
    check("held_pulse_cnt", int'(pl_if.pulse_cnt), 2);
    pl_if.PL_launch = 1'b0;
    tick(3);

    // Re-launch: pulse_cnt restarts from 0
    launch(lc);
    exp_run(lc + 1, 3);
    exp_run(lc + 6, 3);
    exp_end(lc + 9, 2);
    tick(1);
    check("relaunch_cnt_cleared", int'(pl_if.pulse_cnt), 0);
    tick(12);
    pl_if.PL_launch = 1'b0;
    tick(3);

    // 100 clocks per tick
    cfg(2, 1, 1, 1);
    launch(lc);
    exp_run(lc + 1, 100);
    exp_end(lc + 101, 1);
    tick(110);
    pl_if.PL_launch = 1'b0;
    tick(3);

    // Degenerate: num = 0, then width = 0
    cfg(1, 5, 2, 0);
    launch(lc);
    exp_end(lc + 1, 0);
    tick(6);
    pl_if.PL_launch = 1'b0;
    tick(3);
    cfg(1, 0, 2, 3);
    launch(lc);
    exp_end(lc + 1, 0);
    tick(6);
    pl_if.PL_launch = 1'b0;
    tick(3);

    // Abort during second pulse
    cfg(1, 5, 2, 4);
    launch(lc);
    exp_run(lc + 1, 5);
    exp_run(lc + 8, 3);
    tick(10);
    pl_if.PL_launch = 1'b0;
    tick(1);
    check("abort_pl_out", int'(pl_if.PL_out), 0);
    check("abort_busy", int'(pl_if.busy), 0);
    tick(5);
    check("abort_pulse_cnt", int'(pl_if.pulse_cnt), 1);

    // Asynchronous reset mid-HIGH, launch still high at release
    cfg(3, 2, 1, 1);
    launch(lc);
    tick(5);
    check("pre_rst_pl_out", int'(pl_if.PL_out), 1);
    #2 rst = 1'b1;
    #1;
    check("async_rst_pl_out", int'(pl_if.PL_out), 0);
    check("async_rst_busy", int'(pl_if.busy), 0);
    check("async_rst_pulse_cnt", int'(pl_if.pulse_cnt), 0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    tick(20);
    check("no_train_after_rst_busy", int'(pl_if.busy), 0);
    check("no_train_after_rst_out", int'(pl_if.PL_out), 0);
    pl_if.PL_launch = 1'b0;
    tick(3);

    // Fresh edge after reset starts a train
    cfg(1, 1, 1, 1);
    launch(lc);
    exp_run(lc + 1, 1);
    exp_end(lc + 2, 1);
    tick(6);
    pl_if.PL_launch = 1'b0;
    tick(3);

    check("runs_outstanding", run_q.size(), 0);
    check("ends_outstanding", end_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
